// File: rtl/fb_write_arbiter_pkg.sv
// Shared definitions for the framebuffer write arbiter.
//   - default framebuffer geometry
//   - color, coordinate and address widths
//   - ARB/OWN state encoding
package fb_write_arbiter_pkg;

    localparam int PX_WIDTH_DEF  = 160;
    localparam int PX_HEIGHT_DEF = 120;
    localparam int COLOR_W       = 3;
    localparam int COORD_W       = 16;
    localparam int ADDR_W        = 16;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

endpackage

// File: rtl/fb_write_arbiter_pick.sv
// fb_arb_pick: purely combinational winner selection.
// Scans the valid vector starting at index 'start' and wrapping around;
// the first valid requester found wins.
// Ports:
//   valid [N-1:0]  requester valid vector
//   start [PW-1:0] index searched first (highest priority)
//   grant [N-1:0]  one-hot winner, all-zero when nothing is valid
module fb_arb_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant
);

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: arbitrates pixel-write packets from several requesters
// onto a single framebuffer write port. A packet (one primitive) owns the
// port from grant until its accepted last beat; beats are clipped against
// the framebuffer bounds and registered onto the memory port.
// Compile-time option:
//   FBARB_RR_EN  defined -> round-robin arbitration (last owner lowest)
//                undefined -> fixed priority, index 0 highest
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake
//   req_x, req_y      per-requester signed 16-bit coordinates (packed)
//   req_color         per-requester 3-bit color (packed)
//   req_last          final beat of the requester's packet
//   mem_we/addr/data  registered framebuffer write port
//   busy              a packet currently owns the port
//   clip_cnt          saturating count of accepted off-screen beats
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int PX_WIDTH  = PX_WIDTH_DEF,
    parameter int PX_HEIGHT = PX_HEIGHT_DEF,
    parameter int N_REQ     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*COORD_W-1:0]   req_x,
    input  logic [N_REQ*COORD_W-1:0]   req_y,
    input  logic [N_REQ*COLOR_W-1:0]   req_color,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [COLOR_W-1:0]         mem_data,
    output logic                       busy,
    output logic [15:0]                clip_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                 state_q, state_d;
    logic   [N_REQ-1:0]     owner_q;
    logic   [N_REQ-1:0]     grant;
    logic   [PW-1:0]        start_ptr;

    logic   [COORD_W-1:0]   sel_x, sel_y;
    logic   [COLOR_W-1:0]   sel_color;
    logic                   sel_last;
    logic                   accept;
    logic                   on_screen;
    logic   [ADDR_W-1:0]    addr_calc;

`ifdef FBARB_RR_EN
    logic   [PW-1:0]        rr_ptr_q;
    logic   [PW-1:0]        win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_idx = PW'(i);
        end
    end

    // Pointer lands one past the newest owner so it becomes lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (state_q == ARB && |req_valid) begin
            rr_ptr_q <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
        end
    end

    assign start_ptr = rr_ptr_q;
`else
    assign start_ptr = '0;
`endif

    fb_arb_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .valid (req_valid),
        .start (start_ptr),
        .grant (grant)
    );

    // owner_q is one-hot in OWN, so OR-reduction acts as the beat mux.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q[i]) begin
                sel_x     = sel_x     | req_x[i*COORD_W +: COORD_W];
                sel_y     = sel_y     | req_y[i*COORD_W +: COORD_W];
                sel_color = sel_color | req_color[i*COLOR_W +: COLOR_W];
                sel_last  = sel_last  | req_last[i];
            end
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign on_screen = ($signed(sel_x) >= 16'sd0) &&
                       ($signed(sel_x) <  $signed(16'(PX_WIDTH))) &&
                       ($signed(sel_y) >= 16'sd0) &&
                       ($signed(sel_y) <  $signed(16'(PX_HEIGHT)));
    assign addr_calc = sel_y * 16'(PX_WIDTH) + sel_x;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        busy      = 1'b0;
        case (state_q)
            ARB: begin
                if (|req_valid) state_d = OWN;
            end
            OWN: begin
                req_ready = owner_q;
                busy      = 1'b1;
                if (accept && sel_last) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && |req_valid) owner_q <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            clip_cnt <= '0;
        end else begin
            mem_we <= accept && on_screen;
            if (accept) begin
                mem_addr <= addr_calc;
                mem_data <= sel_color;
                if (!on_screen && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*16-1:0] req_x, req_y;
    logic [N*3-1:0]  req_color;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            mem_we;
    logic [15:0]     mem_addr;
    logic [2:0]      mem_data;
    logic            busy;
    logic [15:0]     clip_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    fb_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .req_last  (req_last),
        .req_ready (req_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .clip_cnt  (clip_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input int x, input int y,
                           input int c, input logic l);
        req_valid[i]        = v;
        req_x[i*16 +: 16]   = 16'(x);
        req_y[i*16 +: 16]   = 16'(y);
        req_color[i*3 +: 3] = 3'(c);
        req_last[i]         = l;
    endtask

    initial begin
        int         writes, bad;
        logic [2:0] exp_g;

        rst = 1'b1;
        req_valid = '0; req_x = '0; req_y = '0; req_color = '0; req_last = '0;
        tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_we",    mem_we,    0);
        chk("rst_addr",  mem_addr,  0);
        chk("rst_data",  mem_data,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_clip",  clip_cnt,  0);
        rst = 1'b0;

        // clipping: only (159,119) is on-screen
        set_req(1, 1, -1, 5, 1, 0);
        tick();
        chk("clip_busy",  busy,      1);
        chk("clip_ready", req_ready, 3'b010);
        tick();
        chk("clip_a_we",   mem_we,   0);
        chk("clip_a_cnt",  clip_cnt, 1);
        set_req(1, 1, 160, 0, 1, 0);
        tick();
        chk("clip_b_we",   mem_we,   0);
        chk("clip_b_cnt",  clip_cnt, 2);
        set_req(1, 1, 5, 120, 1, 0);
        tick();
        chk("clip_c_we",   mem_we,   0);
        chk("clip_c_cnt",  clip_cnt, 3);
        set_req(1, 1, 159, 119, 5, 1);
        tick();
        chk("clip_d_we",   mem_we,   1);
        chk("clip_d_addr", mem_addr, 19199);
        chk("clip_d_data", mem_data, 5);
        chk("clip_d_cnt",  clip_cnt, 3);
        chk("clip_d_busy", busy,     0);
        set_req(1, 0, 0, 0, 0, 0);
        tick();
        chk("idle_we",   mem_we,   0);
        chk("idle_addr", mem_addr, 19199);

        // collision: req1 wins over req2, req2 follows after one bubble
        set_req(1, 1, 10, 0, 2, 0);
        set_req(2, 1, 20, 0, 3, 1);
        tick();
        chk("col_busy",   busy,      1);
        chk("col_ready1", req_ready, 3'b010);
        tick();
        chk("col_a_we",   mem_we,    1);
        chk("col_a_addr", mem_addr,  10);
        chk("col_a_data", mem_data,  2);
        chk("col_ready2", req_ready, 3'b010);
        set_req(1, 1, 11, 0, 2, 1);
        tick();
        chk("col_b_addr", mem_addr,  11);
        chk("col_b_busy", busy,      0);
        chk("col_bubble", req_ready, 3'b000);
        set_req(1, 0, 0, 0, 0, 0);
        tick();
        chk("col_r2_ready", req_ready, 3'b100);
        chk("col_r2_we0",   mem_we,    0);
        tick();
        chk("col_r2_we",   mem_we,   1);
        chk("col_r2_addr", mem_addr, 20);
        chk("col_r2_data", mem_data, 3);
        chk("col_r2_busy", busy,     0);
        set_req(2, 0, 0, 0, 0, 0);

        // stall: owner req1 drops valid for 4 cycles while req0 waits
        set_req(1, 1, 1, 1, 6, 0);
        tick();
        chk("stl_ready", req_ready, 3'b010);
        set_req(0, 1, 0, 0, 7, 1);
        tick();
        chk("stl_a_we",   mem_we,   1);
        chk("stl_a_addr", mem_addr, 161);
        set_req(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stl_hold_we",    mem_we,    0);
            chk("stl_hold_busy",  busy,      1);
            chk("stl_hold_ready", req_ready, 3'b010);
        end
        set_req(1, 1, 2, 1, 6, 1);
        tick();
        chk("stl_b_we",   mem_we,   1);
        chk("stl_b_addr", mem_addr, 162);
        chk("stl_b_busy", busy,     0);
        set_req(1, 0, 0, 0, 0, 0);
        tick();
        chk("stl_r0_ready", req_ready, 3'b001);
        tick();
        chk("stl_r0_addr", mem_addr, 0);
        chk("stl_r0_data", mem_data, 7);
        set_req(0, 0, 0, 0, 0, 0);

        // reset in the middle of a packet
        set_req(2, 1, 3, 3, 1, 0);
        tick();
        tick();
        chk("rmp_a_addr", mem_addr, 483);
        set_req(2, 1, 4, 3, 1, 0);
        rst = 1'b1;
        tick();
        chk("rmp_we",    mem_we,    0);
        chk("rmp_busy",  busy,      0);
        chk("rmp_clip",  clip_cnt,  0);
        chk("rmp_ready", req_ready, 0);
        rst = 1'b0;
        set_req(2, 1, 4, 3, 1, 1);
        tick();
        chk("rmp_regrant", req_ready, 3'b100);
        chk("rmp_we2",     mem_we,    0);
        tick();
        chk("rmp_b_we",   mem_we,   1);
        chk("rmp_b_addr", mem_addr, 484);
        set_req(2, 0, 0, 0, 0, 0);

        // full clear sweep by req0
        writes = 0;
        bad    = 0;
        set_req(0, 1, 0, 0, 4, 0);
        tick();
        for (int n = 0; n < 19200; n++) begin
            tick();
            if (mem_we === 1'b1) writes++;
            if (mem_we !== 1'b1 || mem_addr !== 16'(n) || mem_data !== 3'd4) bad++;
            if (n + 1 < 19200)
                set_req(0, 1, (n + 1) % 160, (n + 1) / 160, 4, (n + 1) == 19199);
        end
        chk("sweep_writes", writes, 19200);
        chk("sweep_bad",    bad,    0);
        chk("sweep_busy",   busy,   0);
        chk("sweep_clip",   clip_cnt, 0);
        set_req(0, 0, 0, 0, 0, 0);
        tick();
        chk("sweep_idle_we", mem_we, 0);

        // three continuous 1-beat requesters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, i, 0, i, 1);
        for (int k = 0; k < 6; k++) begin
`ifdef FBARB_RR_EN
            exp_g = 3'b001 << (k % 3);
`else
            exp_g = 3'b001;
`endif
            tick();
            chk("multi_grant", req_ready, exp_g);
            tick();
            chk("multi_we", mem_we, 1);
        end
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
